pixel_packer: RTL and testbench
===============================

PIXEL_PACKER -- requirements
Module: pixel_packer

Interface
REQ-001 SHALL have parameter PIX_WIDTH, default 8: bits per packed pixel, taken from the LSBs of pixel_in.
REQ-002 SHALL have parameter PIX_PER_WORD, default 6: pixels per memory word; legal range 1..8.
REQ-003 SHALL have parameter H_ACTIVE, default 320: pixels per line accepted.
REQ-004 SHALL have parameter V_ACTIVE, default 240: lines per frame accepted.
REQ-005 SHALL have parameter ADDR_WIDTH, default 17: word address width.
REQ-006 SHALL have port clk_pixel, input, 1: sole clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_in, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port pixel_in, input, 10: pixel value (luma); bits [PIX_WIDTH-1:0] are used.
REQ-009 SHALL have port pixel_valid_in, input, 1: single-cycle pixel strobe.
REQ-010 SHALL have port hcount_in, input, 11: column of pixel_in.
REQ-011 SHALL have port vcount_in, input, 10: row of pixel_in.
REQ-012 SHALL have port frame_done_in, input, 1: single-cycle end-of-frame strobe.
REQ-013 SHALL have port word_out, output, PIX_WIDTH*PIX_PER_WORD: packed word.
REQ-014 SHALL have port addr_out, output, ADDR_WIDTH: word address.
REQ-015 SHALL have port wea_out, output, 1: single-cycle write enable for word_out/addr_out.
REQ-016 SHALL have port sync_err_out, output, 1: single-cycle pulse on pixel-order error.
REQ-017 SHALL have port frame_count_out, output, 8: count of frames fully written, wraps at 255.

Function
REQ-018 SHALL implement states IDLE, PACK.
REQ-019 In IDLE, a valid pixel at (0,0) SHALL be packed into lane 0, set word index 0, expected position (1,0), and enter PACK; all other valid pixels SHALL be dropped.
REQ-020 Valid pixels with hcount_in>=H_ACTIVE or vcount_in>=V_ACTIVE SHALL be ignored in any state without affecting expected position.
REQ-021 In PACK, a valid in-range pixel matching the expected position SHALL be placed in lane = pixel count; lane 0 occupies the MSBs of word_out.
REQ-022 Expected position SHALL advance column-first and wrap to (0, row+1) after column H_ACTIVE-1.
REQ-023 When lane PIX_PER_WORD-1 fills, wea_out SHALL assert exactly one cycle later with the full word and current word index on addr_out; pixel count SHALL return to 0 and word index SHALL increment.
REQ-024 Packing SHALL be continuous across line boundaries: word index = floor(linear pixel index / PIX_PER_WORD); no division hardware; running counters only.
REQ-025 A valid in-range pixel not matching the expected position in PACK SHALL pulse sync_err_out the next cycle, discard the partial word without writing, and return to IDLE; if that pixel is (0,0) it SHALL be handled as in REQ-019 in the same cycle.
REQ-026 Accepting pixel (H_ACTIVE-1, V_ACTIVE-1) SHALL write any partial word (unfilled lanes zero) one cycle later, increment frame_count_out, and return to IDLE.
REQ-027 frame_done_in in PACK before the final pixel SHALL write the partial word (if pixel count>0, zero-padded) one cycle later, pulse sync_err_out, not increment frame_count_out, and return to IDLE.
REQ-028 frame_done_in coincident with a valid pixel SHALL process the pixel first, then apply REQ-027 including that pixel.
REQ-029 word_out and addr_out SHALL hold their last values while wea_out is low.
REQ-030 At most one write SHALL occur per cycle; pixel throughput SHALL be one per cycle with no stall.

Reset
REQ-031 rst_in high SHALL immediately force state IDLE and all counters, word_out, addr_out, wea_out, sync_err_out and frame_count_out to 0.
REQ-032 Reset mid-frame SHALL discard any partial word without writing; packing resumes only at the next (0,0).

Verification
REQ-033 Defaults, full 320x240 frame of pixels value=hcount[7:0] back-to-back -> 12800 writes, addresses 0..12799, first word 0x000102030405, frame_count_out=1.
REQ-034 PIX_PER_WORD=4, H_ACTIVE=6, V_ACTIVE=1, values 1..6 -> writes 0x01020304@0, 0x05060000@1.
REQ-035 Defaults, pixel (3,0) skipped -> sync_err_out one pulse, no write, no further writes until next (0,0).
REQ-036 Defaults, frame_done_in with pixel (7,0) (8 pixels accepted) -> writes at 0 and at 1 (lanes 0-1 filled, rest 0), sync_err_out pulse, frame_count_out unchanged.
REQ-037 rst_in asserted after 3 pixels -> all outputs 0 asynchronously, no write; next frame from (0,0) writes address 0.
REQ-038 Pixels with hcount_in=400 interleaved in a valid frame -> ignored, output identical to REQ-033.

Source files
------------

// File: rtl/pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_packer
// Description : Packs a raster-ordered pixel stream into wide memory words.
//               Lane 0 occupies the MSBs of each word. The word index keeps
//               running across line boundaries. Frame completion, early
//               frame_done and pixel-order errors flush or discard the
//               partial word as appropriate.
// Ports       : clk_pixel       - sole clock, rising edge
//               rst_in          - asynchronous active-high reset
//               pixel_in        - pixel value, low PIX_WIDTH bits used
//               pixel_valid_in  - pixel strobe
//               hcount_in       - pixel column
//               vcount_in       - pixel row
//               frame_done_in   - end-of-frame strobe
//               word_out        - packed word, held between writes
//               addr_out        - word address, held between writes
//               wea_out         - single-cycle write enable
//               sync_err_out    - single-cycle order-error / early-end pulse
//               frame_count_out - completed frames, wraps at 255
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_packer #(
  parameter int PIX_WIDTH    = 8,
  parameter int PIX_PER_WORD = 6,
  parameter int H_ACTIVE     = 320,
  parameter int V_ACTIVE     = 240,
  parameter int ADDR_WIDTH   = 17
) (
  input  logic                              clk_pixel,
  input  logic                              rst_in,
  input  logic [9:0]                        pixel_in,
  input  logic                              pixel_valid_in,
  input  logic [10:0]                       hcount_in,
  input  logic [9:0]                        vcount_in,
  input  logic                              frame_done_in,
  output logic [PIX_WIDTH*PIX_PER_WORD-1:0] word_out,
  output logic [ADDR_WIDTH-1:0]             addr_out,
  output logic                              wea_out,
  output logic                              sync_err_out,
  output logic [7:0]                        frame_count_out
);

  localparam int              c_WORD_W    = PIX_WIDTH * PIX_PER_WORD;
  localparam int              c_CNT_W     = 4;
  localparam logic [10:0]     c_H_LAST    = 11'(H_ACTIVE - 1);
  localparam logic [9:0]      c_V_LAST    = 10'(V_ACTIVE - 1);
  localparam logic [c_CNT_W-1:0] c_LANE_LAST = c_CNT_W'(PIX_PER_WORD - 1);

  localparam logic [0:0] c_S_IDLE = 1'b0;
  localparam logic [0:0] c_S_PACK = 1'b1;

  logic [0:0]            r_state;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [c_WORD_W-1:0]   r_buf;
  logic [ADDR_WIDTH-1:0] r_word_idx;
  logic [10:0]           r_exp_h;
  logic [9:0]            r_exp_v;

  logic [PIX_WIDTH-1:0]  w_pix;
  logic                  w_unused_pix;
  logic                  w_in_range, w_origin, w_match, w_start, w_accept;
  logic                  w_seq_err, w_final, w_lane_full, w_fd;
  logic [0:0]            w_pre_state, w_state_nxt;
  logic [c_CNT_W-1:0]    w_base_cnt, w_post_cnt, w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] w_base_idx, w_idx_nxt;
  logic [c_WORD_W-1:0]   w_base_buf, w_new_buf, w_buf_nxt, w_wr_word;
  logic [10:0]           w_exp_h_nxt;
  logic [9:0]            w_exp_v_nxt;
  logic                  w_wr, w_err;

  assign w_pix        = pixel_in[PIX_WIDTH-1:0];
  assign w_unused_pix = ^pixel_in;

  // Out-of-range pixels are invisible to every decision below.
  assign w_in_range = pixel_valid_in && (hcount_in <= c_H_LAST) && (vcount_in <= c_V_LAST);
  assign w_origin   = w_in_range && (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign w_match    = (r_state == c_S_PACK) && w_in_range &&
                      (hcount_in == r_exp_h) && (vcount_in == r_exp_v);
  // A fresh frame starts on (0,0) from IDLE, or as the recovery pixel of an
  // order error in PACK; either way packing restarts from an empty word 0.
  assign w_start    = w_origin && !w_match;
  assign w_accept   = w_match || w_start;
  assign w_seq_err  = (r_state == c_S_PACK) && w_in_range && !w_match;
  assign w_final    = w_accept && (hcount_in == c_H_LAST) && (vcount_in == c_V_LAST);

  assign w_base_cnt = w_start ? '0 : r_cnt;
  assign w_base_idx = w_start ? '0 : r_word_idx;
  assign w_base_buf = w_start ? '0 : r_buf;
  assign w_lane_full = (w_base_cnt == c_LANE_LAST);

  // State register
  always_ff @(posedge clk_pixel or posedge rst_in) begin
    if (rst_in) r_state <= c_S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: the pixel is resolved first, then frame_done_in closes a
  // frame that is still being packed after that pixel.
  always_comb begin
    w_pre_state = r_state;
    if (w_accept)       w_pre_state = w_final ? c_S_IDLE : c_S_PACK;
    else if (w_seq_err) w_pre_state = c_S_IDLE;
    w_fd        = frame_done_in && (w_pre_state == c_S_PACK);
    w_state_nxt = w_fd ? c_S_IDLE : w_pre_state;
  end

  // Datapath / output decode
  always_comb begin
    w_new_buf = w_base_buf;
    for (int l = 0; l < PIX_PER_WORD; l++) begin
      if (w_base_cnt == c_CNT_W'(l))
        w_new_buf[(PIX_PER_WORD-1-l)*PIX_WIDTH +: PIX_WIDTH] = w_pix;
    end

    w_post_cnt = r_cnt;
    w_buf_nxt  = r_buf;
    w_idx_nxt  = r_word_idx;
    w_exp_h_nxt = r_exp_h;
    w_exp_v_nxt = r_exp_v;
    if (w_accept) begin
      w_post_cnt = w_lane_full ? '0 : w_base_cnt + c_CNT_W'(1);
      w_buf_nxt  = w_lane_full ? '0 : w_new_buf;
      w_idx_nxt  = w_lane_full ? w_base_idx + ADDR_WIDTH'(1) : w_base_idx;
      if (hcount_in == c_H_LAST) begin
        w_exp_h_nxt = 11'd0;
        w_exp_v_nxt = vcount_in + 10'd1;
      end else begin
        w_exp_h_nxt = hcount_in + 11'd1;
        w_exp_v_nxt = vcount_in;
      end
    end

    w_cnt_nxt = w_post_cnt;
    if (w_state_nxt == c_S_IDLE) begin
      w_cnt_nxt = '0;
      w_buf_nxt = '0;
    end

    // A completed word already carries every accepted pixel, so the
    // frame_done flush only fires when lanes remain outstanding.
    w_wr      = (w_accept && (w_lane_full || w_final)) || (w_fd && (w_post_cnt != '0));
    w_wr_word = w_accept ? w_new_buf : r_buf;
    w_err     = w_seq_err || w_fd;
  end

  always_ff @(posedge clk_pixel or posedge rst_in) begin
    if (rst_in) begin
      r_cnt           <= '0;
      r_buf           <= '0;
      r_word_idx      <= '0;
      r_exp_h         <= '0;
      r_exp_v         <= '0;
      word_out        <= '0;
      addr_out        <= '0;
      wea_out         <= 1'b0;
      sync_err_out    <= 1'b0;
      frame_count_out <= '0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_buf        <= w_buf_nxt;
      r_word_idx   <= w_idx_nxt;
      r_exp_h      <= w_exp_h_nxt;
      r_exp_v      <= w_exp_v_nxt;
      wea_out      <= w_wr;
      sync_err_out <= w_err;
      if (w_wr) begin
        word_out <= w_wr_word;
        addr_out <= w_base_idx;
      end
      if (w_final) frame_count_out <= frame_count_out + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_packer
// Description : Self-checking bench for pixel_packer. One instance uses the
//               default packing with a short frame, a second uses 4 pixels
//               per word on a single 6-pixel line.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_packer;

  localparam int PW  = 8;
  localparam int PPW = 6;
  localparam int H   = 20;
  localparam int V   = 3;
  localparam int WW  = PW * PPW;

  logic          clk_pixel = 1'b0;
  logic          rst_in = 1'b0;
  logic [9:0]    pixel_in;
  logic          pixel_valid_in;
  logic [10:0]   hcount_in;
  logic [9:0]    vcount_in;
  logic          frame_done_in;
  logic [WW-1:0] word_out;
  logic [16:0]   addr_out;
  logic          wea_out, sync_err_out;
  logic [7:0]    frame_count_out;

  logic [9:0]    b_pixel_in;
  logic          b_pixel_valid_in;
  logic [10:0]   b_hcount_in;
  logic [9:0]    b_vcount_in;
  logic          b_frame_done_in;
  logic [31:0]   b_word_out;
  logic [16:0]   b_addr_out;
  logic          b_wea_out, b_sync_err_out;
  logic [7:0]    b_frame_count_out;

  pixel_packer #(.PIX_WIDTH(PW), .PIX_PER_WORD(PPW), .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_WIDTH(17)) dut (
    .clk_pixel(clk_pixel), .rst_in(rst_in), .pixel_in(pixel_in), .pixel_valid_in(pixel_valid_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .frame_done_in(frame_done_in),
    .word_out(word_out), .addr_out(addr_out), .wea_out(wea_out),
    .sync_err_out(sync_err_out), .frame_count_out(frame_count_out));

  pixel_packer #(.PIX_WIDTH(8), .PIX_PER_WORD(4), .H_ACTIVE(6), .V_ACTIVE(1), .ADDR_WIDTH(17)) dut2 (
    .clk_pixel(clk_pixel), .rst_in(rst_in), .pixel_in(b_pixel_in), .pixel_valid_in(b_pixel_valid_in),
    .hcount_in(b_hcount_in), .vcount_in(b_vcount_in), .frame_done_in(b_frame_done_in),
    .word_out(b_word_out), .addr_out(b_addr_out), .wea_out(b_wea_out),
    .sync_err_out(b_sync_err_out), .frame_count_out(b_frame_count_out));

  always #5 clk_pixel = ~clk_pixel;

  typedef struct { logic [16:0] addr; logic [WW-1:0] word; } wr_t;
  typedef struct { int h; int pix; bit wea; int addr; logic [31:0] word; } vec_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  vec_t tab[6];
  int   n_checks = 0, n_errors = 0, n_writes = 0, n_errs_seen = 0;
  int   w0, e0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write must match the oldest expected write.
  always @(posedge clk_pixel) begin
    #1;
    if (sync_err_out) n_errs_seen++;
    if (wea_out) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr 0x%0h word 0x%0h, required no write", addr_out, word_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 64'(addr_out), 64'(mon_e.addr));
        check("write_word", 64'(word_out), 64'(mon_e.word));
      end
    end
  end

  task automatic put(input bit valid, input int h, input int v, input bit fd, input int pix);
    pixel_valid_in = valid;
    hcount_in      = 11'(h);
    vcount_in      = 10'(v);
    frame_done_in  = fd;
    pixel_in       = 10'(pix);
    @(posedge clk_pixel);
    #2;
  endtask

  task automatic push_word(input int k);
    logic [WW-1:0] w;
    w = '0;
    for (int j = 0; j < PPW; j++) w[(PPW-1-j)*PW +: PW] = 8'(((k*PPW) + j) % H);
    exp_q.push_back('{addr: 17'(k), word: w});
  endtask

  // Full frame, pixel value = column; optionally interleave column-400 pixels.
  task automatic frame(input bit interleave);
    int h, v;
    for (int n = 0; n < H*V; n++) begin
      h = n % H;
      v = n / H;
      if ((n % PPW) == PPW-1) push_word(n / PPW);
      put(1'b1, h, v, 1'b0, h);
      if (interleave && (n % 2 == 0)) put(1'b1, 400, v, 1'b0, 10'h0AA);
    end
    put(1'b0, 0, 0, 1'b0, 0);
    put(1'b0, 0, 0, 1'b0, 0);
  endtask

  initial begin
    pixel_valid_in = 0; hcount_in = 0; vcount_in = 0; frame_done_in = 0; pixel_in = 0;
    b_pixel_valid_in = 0; b_hcount_in = 0; b_vcount_in = 0; b_frame_done_in = 0; b_pixel_in = 0;

    tab[0] = '{h: 0, pix: 1, wea: 1'b0, addr: 0, word: 32'h0};
    tab[1] = '{h: 1, pix: 2, wea: 1'b0, addr: 0, word: 32'h0};
    tab[2] = '{h: 2, pix: 3, wea: 1'b0, addr: 0, word: 32'h0};
    tab[3] = '{h: 3, pix: 4, wea: 1'b1, addr: 0, word: 32'h01020304};
    tab[4] = '{h: 4, pix: 5, wea: 1'b0, addr: 0, word: 32'h01020304};
    tab[5] = '{h: 5, pix: 6, wea: 1'b1, addr: 1, word: 32'h05060000};

    #1 rst_in = 1'b1;
    #1;
    check("reset_word", 64'(word_out), 64'h0);
    check("reset_addr", 64'(addr_out), 64'h0);
    check("reset_wea", 64'(wea_out), 64'h0);
    check("reset_err", 64'(sync_err_out), 64'h0);
    check("reset_frames", 64'(frame_count_out), 64'h0);
    #10 rst_in = 1'b0;
    @(posedge clk_pixel);
    #2;

    // Four pixels per word on one 6-pixel line.
    for (int i = 0; i < 6; i++) begin
      b_pixel_valid_in = 1'b1;
      b_hcount_in = 11'(tab[i].h);
      b_vcount_in = 10'd0;
      b_pixel_in  = 10'(tab[i].pix);
      @(posedge clk_pixel);
      #2;
      check("pp4_wea", 64'(b_wea_out), 64'(tab[i].wea));
      check("pp4_addr", 64'(b_addr_out), 64'(tab[i].addr));
      check("pp4_word", 64'(b_word_out), 64'(tab[i].word));
      check("pp4_err", 64'(b_sync_err_out), 64'h0);
    end
    b_pixel_valid_in = 1'b0;
    @(posedge clk_pixel);
    #2;
    check("pp4_idle_wea", 64'(b_wea_out), 64'h0);
    check("pp4_hold_word", 64'(b_word_out), 64'h05060000);
    check("pp4_frames", 64'(b_frame_count_out), 64'h1);

    // Full frame, back to back.
    w0 = n_writes; e0 = n_errs_seen;
    frame(1'b0);
    check("frame1_writes", 64'(n_writes - w0), 64'(H*V/PPW));
    check("frame1_count", 64'(frame_count_out), 64'h1);
    check("frame1_errs", 64'(n_errs_seen - e0), 64'h0);
    check("frame1_pending", 64'(exp_q.size()), 64'h0);

    // Same frame with out-of-range columns interleaved.
    w0 = n_writes; e0 = n_errs_seen;
    frame(1'b1);
    check("frame2_writes", 64'(n_writes - w0), 64'(H*V/PPW));
    check("frame2_count", 64'(frame_count_out), 64'h2);
    check("frame2_errs", 64'(n_errs_seen - e0), 64'h0);
    check("frame2_pending", 64'(exp_q.size()), 64'h0);

    // Pixel (3,0) skipped: one error, nothing written until the next (0,0).
    w0 = n_writes; e0 = n_errs_seen;
    for (int h = 0; h < 11; h++) if (h != 3) put(1'b1, h, 0, 1'b0, h);
    put(1'b0, 0, 0, 1'b0, 0);
    put(1'b0, 0, 0, 1'b0, 0);
    check("skip_errs", 64'(n_errs_seen - e0), 64'h1);
    check("skip_writes", 64'(n_writes - w0), 64'h0);

    // Early frame_done with pixel (7,0).
    w0 = n_writes; e0 = n_errs_seen;
    for (int h = 0; h < 8; h++) begin
      if (h == 5) exp_q.push_back('{addr: 17'd0, word: 48'h000102030405});
      if (h == 7) exp_q.push_back('{addr: 17'd1, word: 48'h060700000000});
      put(1'b1, h, 0, (h == 7), h);
    end
    put(1'b0, 0, 0, 1'b0, 0);
    put(1'b0, 0, 0, 1'b0, 0);
    check("fd_writes", 64'(n_writes - w0), 64'h2);
    check("fd_errs", 64'(n_errs_seen - e0), 64'h1);
    check("fd_frames", 64'(frame_count_out), 64'h2);
    check("fd_pending", 64'(exp_q.size()), 64'h0);

    // Asynchronous reset after three pixels.
    w0 = n_writes;
    for (int h = 0; h < 3; h++) put(1'b1, h, 0, 1'b0, h);
    pixel_valid_in = 1'b0;
    #1 rst_in = 1'b1;
    #1;
    check("arst_word", 64'(word_out), 64'h0);
    check("arst_addr", 64'(addr_out), 64'h0);
    check("arst_wea", 64'(wea_out), 64'h0);
    check("arst_err", 64'(sync_err_out), 64'h0);
    check("arst_frames", 64'(frame_count_out), 64'h0);
    #2 rst_in = 1'b0;
    @(posedge clk_pixel);
    #2;
    check("arst_writes", 64'(n_writes - w0), 64'h0);
    w0 = n_writes;
    frame(1'b0);
    check("frame3_writes", 64'(n_writes - w0), 64'(H*V/PPW));
    check("frame3_count", 64'(frame_count_out), 64'h1);
    check("frame3_pending", 64'(exp_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
